// File: rtl/ustawienie_pole_if.sv
// Request/response bundle for the bit-field set/clear/toggle/count engine.
interface ustawienie_pole_if #(
  parameter int BITS = 32,
  parameter int CW   = $clog2(BITS) + 1
);
  logic            i_start;
  logic [1:0]      i_mode;
  logic [BITS-1:0] i_arg_A;
  logic [BITS-1:0] i_arg_B;
  logic [BITS-1:0] i_arg_C;
  logic            o_busy;
  logic            o_done;
  logic [BITS-1:0] o_result;
  logic [CW-1:0]   o_count;
  logic            o_error;

  modport master (
    output i_start, i_mode, i_arg_A, i_arg_B, i_arg_C,
    input  o_busy, o_done, o_result, o_count, o_error
  );

  modport slave (
    input  i_start, i_mode, i_arg_A, i_arg_B, i_arg_C,
    output o_busy, o_done, o_result, o_count, o_error
  );
endinterface

// File: rtl/ustawienie_pole.sv
// Bit-field engine: sets, clears, toggles or counts ones in A[C:B], one bit per cycle.
//
// state   | meaning
// --------+----------------------------------------------------------
// S_IDLE  | waiting for i_start; operands latched when it arrives
// S_CHECK | validate B/C against BITS and each other
// S_BUSY  | process bit idx, advance until idx == C
// S_DONE  | publish working word and count (o_done next cycle)
// S_ERR   | publish latched A, count 0, error flag (o_done next cycle)
module ustawienie_pole #(
  parameter int BITS = 32,
  parameter int CW   = $clog2(BITS) + 1
) (
  input  logic            i_clk,
  input  logic            i_rst_n,
  ustawienie_pole_if.slave bus
);

  localparam int IW = (BITS > 1) ? $clog2(BITS) : 1;
  localparam logic [BITS:0] LIM = (BITS+1)'(BITS);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CHECK,
    S_BUSY,
    S_DONE,
    S_ERR
  } state_t;

  state_t state, state_nx;

  logic [BITS-1:0] a_q, b_q, c_q, work_q, work_nx;
  logic [1:0]      mode_q;
  logic [IW-1:0]   idx_q;
  logic [CW-1:0]   cnt_q;
  logic            bad_idx, idx_last, old_bit, new_bit, hit;

  logic            done_q, error_q;
  logic [BITS-1:0] result_q;
  logic [CW-1:0]   count_q;

  // Full-width compares so huge indices are rejected rather than truncated.
  assign bad_idx  = ({1'b0, b_q} >= LIM) || ({1'b0, c_q} >= LIM) || (b_q > c_q);
  assign idx_last = (idx_q == c_q[IW-1:0]);
  assign old_bit  = work_q[idx_q];

  always_comb begin
    new_bit = old_bit;
    hit     = 1'b0;
    work_nx = work_q;
    case (mode_q)
      2'b00:   new_bit = 1'b1;
      2'b01:   new_bit = 1'b0;
      2'b10:   new_bit = ~old_bit;
      default: new_bit = old_bit;
    endcase
    hit = (mode_q == 2'b11) ? old_bit : (old_bit ^ new_bit);
    work_nx[idx_q] = new_bit;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) state <= S_IDLE;
    else          state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE:  if (bus.i_start) state_nx = S_CHECK;
      S_CHECK: state_nx = bad_idx ? S_ERR : S_BUSY;
      S_BUSY:  if (idx_last) state_nx = S_DONE;
      S_DONE:  state_nx = S_IDLE;
      S_ERR:   state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      a_q      <= '0;
      b_q      <= '0;
      c_q      <= '0;
      work_q   <= '0;
      mode_q   <= '0;
      idx_q    <= '0;
      cnt_q    <= '0;
      done_q   <= 1'b0;
      error_q  <= 1'b0;
      result_q <= '0;
      count_q  <= '0;
    end else begin
      done_q <= 1'b0;
      case (state)
        S_IDLE: begin
          if (bus.i_start) begin
            a_q    <= bus.i_arg_A;
            b_q    <= bus.i_arg_B;
            c_q    <= bus.i_arg_C;
            work_q <= bus.i_arg_A;
            mode_q <= bus.i_mode;
          end
        end
        S_CHECK: begin
          idx_q <= b_q[IW-1:0];
          cnt_q <= '0;
        end
        S_BUSY: begin
          work_q <= work_nx;
          cnt_q  <= cnt_q + CW'(hit);
          if (!idx_last) idx_q <= idx_q + 1'b1;
        end
        S_DONE: begin
          done_q   <= 1'b1;
          error_q  <= 1'b0;
          result_q <= work_q;
          count_q  <= cnt_q;
        end
        S_ERR: begin
          done_q   <= 1'b1;
          error_q  <= 1'b1;
          result_q <= a_q;
          count_q  <= '0;
        end
        default: ;
      endcase
    end
  end

  assign bus.o_busy   = (state != S_IDLE);
  assign bus.o_done   = done_q;
  assign bus.o_error  = error_q;
  assign bus.o_result = result_q;
  assign bus.o_count  = count_q;

endmodule

// File: tb/tb_ustawienie_pole.sv
// Scoreboard bench for ustawienie_pole (BITS=32): expectations queued at launch, checked on o_done.
module tb_ustawienie_pole;

  localparam int BITS = 32;
  localparam int CW   = $clog2(BITS) + 1;

  typedef struct {
    logic [31:0] res;
    logic [5:0]  cnt;
    logic        err;
    int          lat;
    int          busy;
  } exp_t;

  logic i_clk;
  logic i_rst_n;

  ustawienie_pole_if #(.BITS(BITS), .CW(CW)) bus ();

  ustawienie_pole #(.BITS(BITS), .CW(CW)) dut (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .bus     (bus)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  exp_t sb[$];
  int   n_vec = 0;
  int   n_bad = 0;
  int   cyc = 0;
  int   start_cyc = 0;
  int   busy_cnt = 0;
  logic prev_done = 1'b0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic exp_t model(input logic [31:0] a, input logic [31:0] b,
                                 input logic [31:0] c, input logic [1:0] mode);
    exp_t e;
    logic nb;
    e.res = a; e.cnt = '0; e.err = 1'b0;
    if (b >= 32 || c >= 32 || b > c) begin
      e.err = 1'b1; e.lat = 2; e.busy = 2;
    end else begin
      for (int i = int'(b); i <= int'(c); i++) begin
        case (mode)
          2'b00:   nb = 1'b1;
          2'b01:   nb = 1'b0;
          2'b10:   nb = ~a[i];
          default: nb = a[i];
        endcase
        if (mode == 2'b11) e.cnt = e.cnt + {5'b0, a[i]};
        else               e.cnt = e.cnt + {5'b0, a[i] ^ nb};
        e.res[i] = nb;
      end
      e.lat  = int'(c - b) + 3;
      e.busy = e.lat;
    end
    return e;
  endfunction

  // Monitor: track start edge, busy cycles, and compare each completion.
  always @(posedge i_clk) begin
    exp_t e;
    cyc++;
    if (i_rst_n && bus.i_start && !bus.o_busy) begin
      start_cyc = cyc;
      busy_cnt  = 0;
    end
    #1;
    if (bus.o_busy) busy_cnt++;
    if (prev_done) chk("done_pulse", {63'b0, bus.o_done}, 64'd0);
    prev_done = bus.o_done;
    if (bus.o_done) begin
      if (sb.size() == 0) begin
        chk("unexpected_done", 64'd1, 64'd0);
      end else begin
        e = sb.pop_front();
        chk("result",  {32'b0, bus.o_result}, {32'b0, e.res});
        chk("count",   {58'b0, bus.o_count},  {58'b0, e.cnt});
        chk("error",   {63'b0, bus.o_error},  {63'b0, e.err});
        chk("latency", 64'(cyc - start_cyc),  64'(e.lat));
        chk("busy_cycles", 64'(busy_cnt),     64'(e.busy));
      end
    end
  end

  task automatic launch(input logic [31:0] a, input logic [31:0] b, input logic [31:0] c,
                        input logic [1:0] mode, input exp_t e);
    sb.push_back(e);
    @(negedge i_clk);
    bus.i_arg_A = a; bus.i_arg_B = b; bus.i_arg_C = c; bus.i_mode = mode;
    bus.i_start = 1'b1;
    @(negedge i_clk);
    bus.i_start = 1'b0;
  endtask

  task automatic wait_idle();
    int t = 0;
    while (sb.size() != 0 && t < 200) begin
      @(negedge i_clk);
      t++;
    end
    if (sb.size() != 0) begin
      chk("timeout", 64'(sb.size()), 64'd0);
      sb.delete();
    end
    @(negedge i_clk);
  endtask

  function automatic exp_t mk(input logic [31:0] r, input logic [5:0] n, input logic er,
                              input int lat);
    exp_t e;
    e.res = r; e.cnt = n; e.err = er; e.lat = lat; e.busy = lat;
    return e;
  endfunction

  task automatic run(input logic [31:0] a, input logic [31:0] b, input logic [31:0] c,
                     input logic [1:0] mode, input exp_t e);
    launch(a, b, c, mode, e);
    wait_idle();
  endtask

  initial begin
    logic [31:0] ra, rb, rc;
    logic [1:0]  rm;

    i_rst_n = 1'b0;
    bus.i_start = 1'b0; bus.i_mode = 2'b00;
    bus.i_arg_A = '0; bus.i_arg_B = '0; bus.i_arg_C = '0;
    repeat (3) @(negedge i_clk);
    chk("rst_busy",   {63'b0, bus.o_busy},   64'd0);
    chk("rst_done",   {63'b0, bus.o_done},   64'd0);
    chk("rst_error",  {63'b0, bus.o_error},  64'd0);
    chk("rst_result", {32'b0, bus.o_result}, 64'd0);
    chk("rst_count",  {58'b0, bus.o_count},  64'd0);
    i_rst_n = 1'b1;
    @(negedge i_clk);

    run(32'h0000_0000, 32'd3,  32'd6,  2'b00, mk(32'h0000_0078, 6'd4,  1'b0, 6));
    run(32'hFFFF_FFFF, 32'd0,  32'd31, 2'b01, mk(32'h0000_0000, 6'd32, 1'b0, 34));
    run(32'h0000_00F0, 32'd4,  32'd11, 2'b10, mk(32'h0000_0F00, 6'd8,  1'b0, 10));
    run(32'h0000_00F0, 32'd0,  32'd7,  2'b11, mk(32'h0000_00F0, 6'd4,  1'b0, 10));

    run(32'h1234_5678, 32'd33,        32'd40, 2'b00, mk(32'h1234_5678, 6'd0, 1'b1, 2));
    run(32'hCAFE_F00D, 32'hFFFF_FFFF, 32'd0,  2'b10, mk(32'hCAFE_F00D, 6'd0, 1'b1, 2));
    run(32'h0BAD_BEEF, 32'd10,        32'd5,  2'b01, mk(32'h0BAD_BEEF, 6'd0, 1'b1, 2));
    run(32'h0000_0001, 32'd0,         32'd32, 2'b00, mk(32'h0000_0001, 6'd0, 1'b1, 2));

    run(32'h0000_0000, 32'd31, 32'd31, 2'b00, mk(32'h8000_0000, 6'd1, 1'b0, 3));
    run(32'h0000_00FF, 32'd0,  32'd3,  2'b00, mk(32'h0000_00FF, 6'd0, 1'b0, 6));
    run(32'h0000_0005, 32'd0,  32'd0,  2'b11, mk(32'h0000_0005, 6'd1, 1'b0, 3));

    // Second start while busy must be dropped; operands changed mid-run must not leak in.
    launch(32'h0000_0000, 32'd0, 32'd15, 2'b10, mk(32'h0000_FFFF, 6'd16, 1'b0, 18));
    repeat (5) @(negedge i_clk);
    bus.i_arg_A = 32'hFFFF_FFFF; bus.i_arg_B = 32'd2; bus.i_arg_C = 32'd3; bus.i_mode = 2'b01;
    bus.i_start = 1'b1;
    @(negedge i_clk);
    bus.i_start = 1'b0;
    wait_idle();
    repeat (4) @(negedge i_clk);
    chk("hold_result", {32'b0, bus.o_result}, 64'h0000_FFFF);
    chk("hold_count",  {58'b0, bus.o_count},  64'd16);

    for (int k = 0; k < 6; k++) begin
      ra = $urandom;
      rb = 32'($urandom_range(0, 31));
      rc = 32'($urandom_range(int'(rb), 31));
      rm = 2'($urandom_range(0, 3));
      run(ra, rb, rc, rm, model(ra, rb, rc, rm));
    end

    // Reset mid-BUSY: outputs clear asynchronously, no completion, restart on first edge.
    run(32'h0000_0000, 32'd0, 32'd7, 2'b00, mk(32'h0000_00FF, 6'd8, 1'b0, 10));
    launch(32'h0000_0000, 32'd0, 32'd31, 2'b00, mk(32'hFFFF_FFFF, 6'd32, 1'b0, 34));
    repeat (10) @(negedge i_clk);
    #2;
    i_rst_n = 1'b0;
    sb.delete();
    #1;
    chk("rstmid_busy",   {63'b0, bus.o_busy},   64'd0);
    chk("rstmid_done",   {63'b0, bus.o_done},   64'd0);
    chk("rstmid_error",  {63'b0, bus.o_error},  64'd0);
    chk("rstmid_result", {32'b0, bus.o_result}, 64'd0);
    chk("rstmid_count",  {58'b0, bus.o_count},  64'd0);
    repeat (3) @(negedge i_clk);
    sb.push_back(mk(32'h0000_0000, 6'd4, 1'b0, 6));
    bus.i_arg_A = 32'h0000_000F; bus.i_arg_B = 32'd0; bus.i_arg_C = 32'd3; bus.i_mode = 2'b01;
    bus.i_start = 1'b1;
    i_rst_n = 1'b1;
    @(negedge i_clk);
    bus.i_start = 1'b0;
    wait_idle();
    repeat (40) @(negedge i_clk);
    chk("sb_empty", 64'(sb.size()), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "global timeout");
  end

endmodule

// File: doc/ustawienie_pole.md
USTAWIENIE_POLE -- requirements
Module: ustawienie_pole

Interface
REQ-001 The block SHALL have parameter BITS, default 32, meaning operand width and bit-index range 0..BITS-1.
REQ-002 The block SHALL have parameter CW, default $clog2(BITS)+1, meaning width of o_count.
REQ-003 The block SHALL have port i_clk, input, 1, meaning the single clock; all state changes on its rising edge.
REQ-004 The block SHALL have port i_rst_n, input, 1, meaning reset, asynchronous and active-low.
REQ-005 The block SHALL have port i_start, input, 1, meaning a request to start an operation, sampled only in IDLE.
REQ-006 The block SHALL have port i_mode, input, 2, meaning the operation: 00 set, 01 clear, 10 toggle, 11 count-ones (A unchanged).
REQ-007 The block SHALL have port i_arg_A, input, BITS, meaning the operand word.
REQ-008 The block SHALL have port i_arg_B, input, BITS, meaning the low bit index of the field (unsigned).
REQ-009 The block SHALL have port i_arg_C, input, BITS, meaning the high bit index of the field (unsigned).
REQ-010 The block SHALL have port o_busy, output, 1, meaning high in every state except IDLE.
REQ-011 The block SHALL have port o_done, output, 1, meaning a one-cycle completion pulse.
REQ-012 The block SHALL have port o_result, output, BITS, meaning the resulting word.
REQ-013 The block SHALL have port o_count, output, CW, meaning the number of bits changed (modes 00-10) or the number of ones in the field (mode 11).
REQ-014 The block SHALL have port o_error, output, 1, meaning the last operation had an invalid index.

Function
REQ-015 The block SHALL implement states IDLE, CHECK, BUSY, DONE and ERR.
REQ-016 In IDLE with i_start=1, the block SHALL latch i_arg_A, i_arg_B, i_arg_C and i_mode into working registers and go to CHECK.
REQ-017 In CHECK, if B>=BITS, C>=BITS or B>C, the block SHALL go to ERR; otherwise it SHALL set idx=B, clear the working count, and go to BUSY.
REQ-018 In BUSY, each cycle the block SHALL process exactly one bit idx of the working word per i_mode, increment the count when the bit changes (modes 00-10) or is 1 (mode 11), then set idx=idx+1 or go to DONE if idx==C.
REQ-019 BUSY SHALL last exactly C-B+1 cycles, and o_done SHALL assert N+2 cycles after the start-sampling edge, where N=C-B+1.
REQ-020 In DONE, the block SHALL assert o_done=1, o_error=0, o_result=working word and o_count=working count for one cycle, then return to IDLE.
REQ-021 In ERR, the block SHALL assert o_done=1, o_error=1, o_result=latched A and o_count=0 for one cycle, then return to IDLE.
REQ-022 o_result, o_count and o_error SHALL update only on entry to DONE or ERR and SHALL hold until the next completion.
REQ-023 i_start SHALL be ignored while o_busy=1, with no queuing.
REQ-024 Input changes after the start-sampling edge SHALL not affect the running operation.
REQ-025 A field of a single bit (B==C) SHALL be legal, giving one BUSY cycle.
REQ-026 Index comparisons SHALL use the full BITS-wide unsigned values, so that values such as 0xFFFFFFFF are out of range and never truncated.
REQ-027 o_count SHALL never overflow, since its maximum is BITS.

Reset
REQ-028 While i_rst_n=0, asynchronously, the block SHALL set state=IDLE and drive o_busy, o_done, o_error, o_result and o_count to 0.
REQ-029 Reset during CHECK, BUSY, DONE or ERR SHALL abort the operation with no o_done pulse, and the block SHALL accept a new i_start on the first edge after release.

Verification (BITS=32)
REQ-030 The bench SHALL drive A=0x00000000, B=3, C=6, mode 00 and check 4 BUSY cycles, o_done 6 cycles after start, o_result=0x00000078, o_count=4, o_error=0.
REQ-031 The bench SHALL drive A=0xFFFFFFFF, B=0, C=31, mode 01 and check o_result=0x00000000, o_count=32, o_done 34 cycles after start.
REQ-032 The bench SHALL drive A=0x000000F0, B=4, C=11, mode 10 and check o_result=0x00000F00, o_count=8, and then mode 11 with A=0x000000F0, B=0, C=7 giving o_result=0x000000F0, o_count=4.
REQ-033 The bench SHALL drive B=33, C=40, then B=0xFFFFFFFF, C=0, then B=10, C=5 and check for each o_done and o_error 2 cycles after start, o_result=A, o_count=0.
REQ-034 The bench SHALL pulse i_start again during BUSY and check that it is ignored and the result matches the first operation only.
REQ-035 The bench SHALL drop i_rst_n mid-BUSY and check all outputs 0 immediately, no o_done, and a clean operation after release.
